// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Maps transfer size and low address bits to a byte-lane enable vector,
// flagging addresses that are not aligned to the transfer size.
module ahb_byte_strobe
  import ahb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                    i_size,
  input  logic [$clog2(DATA_W/8)-1:0]   i_addr_lo,
  output logic [DATA_W/8-1:0]           o_strb,
  output logic                          o_align_err
);

  localparam int NB = DATA_W / 8;

  // A lane is enabled when it shares the same size-aligned block as the address.
  always_comb begin
    o_strb = '0;
    for (int i = 0; i < NB; i++) begin
      if (((i ^ int'(i_addr_lo)) >> i_size) == 0)
        o_strb[i] = 1'b1;
    end
    o_align_err = ((int'(i_addr_lo) & ((1 << i_size) - 1)) != 0);
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word memory with byte-lane writes, programmable
// wait states and a two-cycle ERROR response for illegal transfers.
//
// state | meaning
// IDLE  | no data phase owed, zero-wait OKAY
// WAIT  | legal transfer accepted, counting down wait cycles
// DATA  | last data-phase cycle: write commits, read data valid
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int MW = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? HSIZE_DWORD : HSIZE_WORD;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [MW-1:0]     r_word;
  logic              r_write;
  logic [NB-1:0]     r_strb;
  logic [DATA_W-1:0] r_mem [DEPTH];

  htrans_t           w_trans;
  logic              w_accept;
  logic              w_align_err;
  logic              w_illegal;
  logic              w_phase_end;
  logic              w_load;
  logic [NB-1:0]     w_strb;

  ahb_byte_strobe #(.DATA_W(DATA_W)) u_strobe (
    .i_size      (HSIZE),
    .i_addr_lo   (HADDR[LW-1:0]),
    .o_strb      (w_strb),
    .o_align_err (w_align_err)
  );

  assign w_trans   = htrans_t'(HTRANS);
  assign w_accept  = HSEL && HREADY && (w_trans == NONSEQ || w_trans == SEQ);
  assign w_illegal = (HSIZE > MAX_SIZE) || w_align_err ||
                     (HADDR[ADDR_W-1:LW] >= (ADDR_W-LW)'(DEPTH));

  // IDLE, DATA and ERR2 all end their cycle with HREADYOUT high, so a new
  // address phase may be taken there.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_end = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      ST_WAIT: begin
        if (r_cnt <= 3'd1) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_phase_end = 1'b1;
    endcase
    if (w_phase_end) begin
      w_state_nxt = ST_IDLE;
      if (w_accept) begin
        w_load = 1'b1;
        if (w_illegal) begin
          w_state_nxt = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 3'(WAIT_STATES);
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_write <= 1'b0;
      r_strb  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_word  <= HADDR[LW +: MW];
        r_write <= HWRITE;
        r_strb  <= w_strb;
      end
    end
  end

  // Memory is never reset; a reset edge aborts a pending write.
  always_ff @(posedge HCLK) begin
    if (HRESETn && r_state == ST_DATA && r_write) begin
      for (int i = 0; i < NB; i++) begin
        if (r_strb[i])
          r_mem[r_word][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = !(r_state == ST_WAIT || r_state == ST_ERR1);
  assign HRESP     = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (r_state == ST_DATA && !r_write) ? r_mem[r_word] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: a zero-wait and a three-wait instance
// share one bus driver; a byte-level memory model predicts every response.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        sel0, sel1;
  logic [31:0] rd0, rd1;
  logic        ro0, ro1, rs0, rs1;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(ro0),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(ro1),
    .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  xfer_t      xq[$];
  exp_t       sb[$];
  logic [7:0] mref [2][4096];
  int         checks = 0;
  int         errors = 0;
  int         tgt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void add(input logic s, input logic [1:0] tr, input logic wr,
                              input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    xfer_t x;
    x.sel = s; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = wd;
    xq.push_back(x);
  endfunction

  // Reference: a transfer touches bytes addr..addr+2**size-1; reads return the whole word.
  function automatic void model_issue(input xfer_t x);
    exp_t e;
    int   a;
    int   wa;
    if (!x.sel || !x.trans[1]) return;
    e.err = 1'b0; e.rd = !x.wr; e.data = '0;
    if (x.size > 3'd2 || (x.addr % (32'd1 << x.size)) != 0 || (x.addr / 4) >= 32'd1024) begin
      e.err = 1'b1; e.rd = 1'b0;
    end else if (x.wr) begin
      for (int b = 0; b < (1 << x.size); b++) begin
        a = int'(x.addr) + b;
        mref[tgt][a] = x.wdata[8*(a%4) +: 8];
      end
    end else begin
      wa = int'(x.addr) & ~3;
      e.data = {mref[tgt][wa+3], mref[tgt][wa+2], mref[tgt][wa+1], mref[tgt][wa]};
    end
    sb.push_back(e);
  endfunction

  task automatic wait_accept();
    logic r;
    int   g;
    g = 0;
    do begin
      @(negedge HCLK);
      r = (tgt == 0) ? ro0 : ro1;
      @(posedge HCLK); #1;
      g++;
    end while (!r && g < 40);
    if (!r) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=stalled required=ready");
    end
  endtask

  task automatic run_q();
    xfer_t       x;
    logic [31:0] pend;
    pend = '0;
    while (xq.size() > 0) begin
      x = xq.pop_front();
      model_issue(x);
      sel0 = x.sel && (tgt == 0);
      sel1 = x.sel && (tgt == 1);
      HADDR = x.addr; HTRANS = x.trans; HWRITE = x.wr; HSIZE = x.size; HWDATA = pend;
      wait_accept();
      if (x.sel && x.trans[1]) pend = x.wdata;
    end
    sel0 = 1'b0; sel1 = 1'b0; HTRANS = IDLE; HWDATA = pend;
    wait_accept();
    HWDATA = '0;
    wait_accept();
  endtask

  task automatic gen_random(input int n);
    int          k;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [1:0]  tr;
    logic        s;
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(0, 11);
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      s  = 1'b1;
      tr = ($urandom_range(0, 1) == 0) ? NONSEQ : SEQ;
      if (k == 0) tr = IDLE;
      else if (k == 1) tr = BUSY;
      else if (k == 2) s = 1'b0;
      if (k == 3) begin sz = 3'd2; a = a | 32'd1; end
      else if (k == 4) begin sz = 3'd3; a = a & ~32'd7; end
      else a = a & ~((32'd1 << sz) - 32'd1);
      add(s, tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
    end
  endtask

  // Monitor: pops one expectation whenever the selected slave completes a data phase.
  bit          act = 1'b0;
  bit          sawerr = 1'b0;
  int          lowcnt = 0;
  logic        m_rdy, m_rsp, m_sel;
  logic [31:0] m_rd;
  exp_t        m_e;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      act = 1'b0; lowcnt = 0; sawerr = 1'b0;
    end else begin
      m_rdy = (tgt == 0) ? ro0 : ro1;
      m_rsp = (tgt == 0) ? rs0 : rs1;
      m_rd  = (tgt == 0) ? rd0 : rd1;
      m_sel = (tgt == 0) ? sel0 : sel1;
      if (act) begin
        if (!m_rdy) begin
          lowcnt++;
          if (m_rsp) sawerr = 1'b1;
        end else begin
          act = 1'b0;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow actual=empty required=entry");
          end else begin
            m_e = sb.pop_front();
            if (m_e.err) begin
              chk("err_resp", 32'(m_rsp), 32'd1);
              chk("err_len", 32'(lowcnt), 32'd1);
              chk("err_first_resp", 32'(sawerr), 32'd1);
            end else begin
              chk("ok_resp", 32'(m_rsp), 32'd0);
              chk("ok_waits", 32'(lowcnt), (tgt == 0) ? 32'd0 : 32'd3);
              chk("ok_wait_resp", 32'(sawerr), 32'd0);
              chk(m_e.rd ? "rdata" : "write_rdata", m_rd, m_e.data);
            end
          end
        end
      end else begin
        chk("idle_rdy", 32'(m_rdy), 32'd1);
        chk("idle_resp", 32'(m_rsp), 32'd0);
        chk("idle_rdata", m_rd, 32'd0);
      end
      if (m_rdy && m_sel && HTRANS[1]) begin
        act = 1'b1; lowcnt = 0; sawerr = 1'b0;
      end
    end
  end

  initial begin
    HRESETn = 1'b0; sel0 = 1'b0; sel1 = 1'b0; HADDR = '0; HTRANS = IDLE;
    HWRITE = 1'b0; HSIZE = 3'd0; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_rdy0", 32'(ro0), 32'd1);
    chk("rst_resp0", 32'(rs0), 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_rdy1", 32'(ro1), 32'd1);
    chk("rst_resp1", 32'(rs1), 32'd0);
    chk("rst_rdata1", rd1, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    tgt = 0;
    for (int w = 0; w < 64; w++) add(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'(w * 4), $urandom);
    run_q();
    add(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    add(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    run_q();
    add(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h11223344);
    add(1'b1, NONSEQ, 1'b1, HSIZE_BYTE, 32'h13, 32'hAA000000);
    add(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    run_q();
    add(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h02, 32'h0);
    add(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h1000, 32'h0);
    add(1'b1, NONSEQ, 1'b0, HSIZE_DWORD, 32'h00, 32'h0);
    add(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'h06, 32'hFFFFFFFF);
    add(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'h1000, 32'hFFFFFFFF);
    add(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'h0);
    add(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h04, 32'h0);
    run_q();
    add(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'hA5A5_0020);
    add(1'b1, BUSY,   1'b1, HSIZE_WORD, 32'h24, 32'h0);
    add(1'b1, SEQ,    1'b1, HSIZE_WORD, 32'h24, 32'h5A5A_0024);
    add(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    add(1'b1, BUSY,   1'b0, HSIZE_WORD, 32'h24, 32'h0);
    add(1'b1, SEQ,    1'b0, HSIZE_WORD, 32'h24, 32'h0);
    run_q();
    gen_random(80);
    run_q();

    tgt = 1;
    for (int w = 0; w < 64; w++) add(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'(w * 4), $urandom);
    run_q();
    add(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    add(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h1000, 32'h0);
    run_q();
    gen_random(40);
    run_q();

    // Reset in the middle of a waited write must abort it.
    sel1 = 1'b1; HADDR = 32'h40; HTRANS = NONSEQ; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
    wait_accept();
    sel1 = 1'b0; HTRANS = IDLE; HWDATA = 32'hCAFEF00D;
    @(negedge HCLK);
    chk("wait_before_rst", 32'(ro1), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_abort_rdy", 32'(ro1), 32'd1);
    chk("rst_abort_resp", 32'(rs1), 32'd0);
    @(posedge HCLK); #1;
    add(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
    run_q();

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
